// File: rtl/relational_flags_unit.sv
`default_nettype none
// ============================================================================
// Module  : relational_flags_unit
// Brief   : Latches one-hot comparator relation flags {Z,G,L} and resolves
//           branch-condition queries against them, returning a registered
//           taken/not-taken result. Also keeps a sticky malformed-flag error
//           and a saturating count of taken branches.
// Revision: 1.0 - initial release
// ============================================================================
module relational_flags_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_valid,
  input  logic             AeqB,
  input  logic             AmaB,
  input  logic             AmeB,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  output logic             br_ready,
  output logic             res_valid,
  output logic             res_taken,
  output logic [2:0]       flags,
  output logic             flags_valid,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [2:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_taken_q, pend_taken_d;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       flag_set;
  logic             one_hot;
  logic             legal_wr;
  logic             bad_wr;
  logic             accept;
  logic             cond_true;

  // Decode the comparator flag set and the branch condition against the held flags.
  always_comb begin
    flag_set  = {AeqB, AmaB, AmeB};
    one_hot   = (flag_set == 3'b100) || (flag_set == 3'b010) || (flag_set == 3'b001);
    legal_wr  = cmp_valid && one_hot;
    bad_wr    = cmp_valid && !one_hot;
    // ALWAYS/NEVER do not depend on the flags, so they never stall in EMPTY.
    br_ready  = (state_q == ST_HOLD) || (br_cond == 3'b110) || (br_cond == 3'b111);
    accept    = br_valid && br_ready;
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = flags_q[2];
      3'b001:  cond_true = !flags_q[2];
      3'b010:  cond_true = flags_q[1];
      3'b011:  cond_true = flags_q[0];
      3'b100:  cond_true = flags_q[1] | flags_q[2];
      3'b101:  cond_true = flags_q[0] | flags_q[2];
      3'b110:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state: FSM, flag register, sticky error, two-stage result pipeline, counter.
  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    err_d        = err_q;
    pend_valid_d = accept;
    pend_taken_d = pend_taken_q;
    res_valid_d  = pend_valid_q;
    res_taken_d  = res_taken_q;
    cnt_d        = cnt_q;

    if (legal_wr) begin
      flags_d = flag_set;
      state_d = ST_HOLD;
    end

    // A malformed write in the same cycle as a clear leaves the error set.
    if (bad_wr) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    // The condition is captured with the flags held at the accepting edge,
    // so a same-cycle flag write only affects later queries.
    if (accept) begin
      pend_taken_d = cond_true;
    end

    if (pend_valid_q) begin
      res_taken_d = pend_taken_q;
      if (pend_taken_q && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops everything, including any query in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      flags_q      <= 3'b000;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_taken_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
      pend_valid_q <= pend_valid_d;
      pend_taken_q <= pend_taken_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      cnt_q        <= cnt_d;
    end
  end

  assign flags       = flags_q;
  assign flags_valid = (state_q == ST_HOLD);
  assign err         = err_q;
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign taken_cnt   = cnt_q;

endmodule
`default_nettype wire
